// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a shared seven-segment decoder, with lamp test
// and frame-synchronous value updates. Optional feature macro: LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK_CYC   = 8,
  parameter int LAMP_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    dash_mode,
  input  logic                    lamp_test,
  output logic [3:0]              digit,
  output logic [1:0]              pattern,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int                IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int                VAL_W     = 4 * NUM_DIGITS;
  localparam logic [15:0]       SLOT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0]       BLANK_LEN = 16'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]        FRAMES    = 8'(LAMP_FRAMES);

  localparam logic [1:0] PAT_NUMBER = 2'd0;
  localparam logic [1:0] PAT_ALL    = 2'd1;
  localparam logic [1:0] PAT_DASH   = 2'd3;

  typedef enum logic {
    LAMP = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              frameCnt_q, frameCnt_d;
  logic [15:0]             slotCnt_q, slotCnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [VAL_W-1:0]        display_q, display_d;
  logic [VAL_W-1:0]        shadow_q, shadow_d;
  logic                    shadowFull_q, shadowFull_d;
  logic                    dash_q, dash_d;
  logic [3:0]              digit_q, digit_d;
  logic [1:0]              pattern_q, pattern_d;
  logic [NUM_DIGITS-1:0]   digitEn_q, digitEn_d;
  logic                    frameTick_q, frameTick_d;
  logic                    ready_q, ready_d;

  state_e                  curState;
  logic [7:0]              curFrame;
  logic [15:0]             curSlot;
  logic [IDX_W-1:0]        curIdx;
  logic                    frameStart;
  logic                    transfer;
  logic [3:0]              nibble;
`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0]        msbIdx;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LAMP;
      frameCnt_q   <= '0;
      slotCnt_q    <= '0;
      idx_q        <= '0;
      display_q    <= '0;
      shadow_q     <= '0;
      shadowFull_q <= 1'b0;
      dash_q       <= 1'b0;
      digit_q      <= 4'd0;
      pattern_q    <= PAT_ALL;
      digitEn_q    <= '0;
      frameTick_q  <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frameCnt_q   <= frameCnt_d;
      slotCnt_q    <= slotCnt_d;
      idx_q        <= idx_d;
      display_q    <= display_d;
      shadow_q     <= shadow_d;
      shadowFull_q <= shadowFull_d;
      dash_q       <= dash_d;
      digit_q      <= digit_d;
      pattern_q    <= pattern_d;
      digitEn_q    <= digitEn_d;
      frameTick_q  <= frameTick_d;
      ready_q      <= ready_d;
    end
  end

  // The counters hold the scan position that the next edge will present; a lamp_test
  // pulse overrides that position so the new frame is presented on the same edge.
  always_comb begin
    curState   = lamp_test ? LAMP : state_q;
    curFrame   = lamp_test ? 8'd0 : frameCnt_q;
    curSlot    = lamp_test ? 16'd0 : slotCnt_q;
    curIdx     = lamp_test ? '0 : idx_q;
    frameStart = (curSlot == 16'd0) && (curIdx == '0);
    transfer   = value_valid && ready_q;

    state_d      = curState;
    frameCnt_d   = curFrame;
    display_d    = display_q;
    shadow_d     = shadow_q;
    shadowFull_d = shadowFull_q;
    dash_d       = dash_q;

    if (frameStart) begin
      if (shadowFull_q) begin
        display_d    = shadow_q;
        shadowFull_d = 1'b0;
      end
      dash_d = dash_mode;
      if (curState == LAMP) begin
        if (curFrame >= FRAMES) begin
          state_d = RUN;
        end else begin
          frameCnt_d = curFrame + 8'd1;
        end
      end
    end

    // A capture on a frame edge lands after the copy, so it waits for the next frame.
    if (transfer) begin
      shadow_d     = value_in;
      shadowFull_d = 1'b1;
    end
    ready_d = !shadowFull_d;

    if (curSlot == SLOT_LAST) begin
      slotCnt_d = 16'd0;
      idx_d     = (curIdx == IDX_LAST) ? '0 : curIdx + 1'b1;
    end else begin
      slotCnt_d = curSlot + 16'd1;
      idx_d     = curIdx;
    end

    frameTick_d = frameStart;
    digitEn_d   = (curSlot < BLANK_LEN) ? '0 : (NUM_DIGITS'(1) << curIdx);

    nibble = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (curIdx == IDX_W'(i)) begin
        nibble = display_d[4*i +: 4];
      end
    end

`ifdef LEADING_ZERO_BLANK_EN
    msbIdx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (display_d[4*i +: 4] != 4'd0) begin
        msbIdx = IDX_W'(i);
      end
    end
    if (curIdx > msbIdx) begin
      nibble = 4'hF;
    end
`endif

    // Decoder inputs only move at slot starts, while the digit enables are all low.
    digit_d   = digit_q;
    pattern_d = pattern_q;
    if (curSlot == 16'd0) begin
      if (state_d == LAMP) begin
        pattern_d = PAT_ALL;
        digit_d   = 4'd0;
      end else if (dash_d) begin
        pattern_d = PAT_DASH;
        digit_d   = 4'd0;
      end else begin
        pattern_d = PAT_NUMBER;
        digit_d   = nibble;
      end
    end
  end

  assign value_ready = ready_q;
  assign digit       = digit_q;
  assign pattern     = pattern_q;
  assign digit_en    = digitEn_q;
  assign frame_tick  = frameTick_q;

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexing controller for the shared seven-segment decoder. One decoder drives NUM_DIGITS common-segment displays.
- Each cycle it selects which digit is active and supplies that digit's BCD nibble and pattern code. The decoder's digit/pattern inputs connect straight to this block's outputs.
- After reset, and on request, it sequences a power-on lamp test.
- New display values are taken through a valid/ready handshake and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits. Legal range 1..8.
- SCAN_DIV, 1000: clock cycles per digit slot. Legal range 2..65535.
- BLANK_CYC, 8: blanking cycles at the start of each slot (anti-ghosting). Must be less than SCAN_DIV; 0 is allowed.
- LAMP_FRAMES, 64: duration of the lamp test, in full scan frames. Legal range 1..255.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous reset, active low.
- value_in, input, 4*NUM_DIGITS: BCD digits. Nibble i goes to digit i; digit 0 is the least significant.
- value_valid, input, 1: value_in is valid.
- value_ready, output, 1: controller can accept value_in.
- dash_mode, input, 1: level input; when set, every digit shows the middle bar.
- lamp_test, input, 1: pulse that (re)starts the lamp test.
- digit, output, 4: nibble sent to the decoder.
- pattern, output, 2: pattern code sent to the decoder (0 = number, 1 = all segments, 3 = middle bar).
- digit_en, output, NUM_DIGITS: one-hot digit enable, active high.
- frame_tick, output, 1: one-cycle pulse at the start of every frame.

Behaviour:
- Reset (rst_n low at a clock edge):
  - digit=0, pattern=1, digit_en=0, value_ready=0, frame_tick=0.
  - Display register = 0, shadow register empty, dash register = 0.
  - Slot counter = 0, digit index = 0, frame counter = 0, state = LAMP.
  - Reset takes effect at any point, including mid-slot or mid-lamp-test; all in-progress activity is discarded.
- Timing:
  - All outputs are registered.
  - A slot lasts SCAN_DIV cycles: digit_en = 0 for the first BLANK_CYC cycles, then the one-hot bit for the current index for SCAN_DIV-BLANK_CYC cycles.
  - The index increments 0..NUM_DIGITS-1 and wraps to 0. One frame = NUM_DIGITS*SCAN_DIV cycles.
  - frame_tick is high in the first output cycle of slot 0 in every frame, including the first frame after reset.
  - digit and pattern change only at slot starts, never while digit_en is non-zero.
- States:
  - LAMP: pattern=1, digit=0. Counts frame boundaries; after LAMP_FRAMES complete frames, go to RUN at the next frame boundary.
  - RUN: pattern=3 if the dash register is set, else pattern=0 with digit = display register nibble[index].
  - A lamp_test pulse in any state: on the next edge, state = LAMP, frame counter = 0, slot counter = 0, index = 0 (a new frame starts, so frame_tick fires). The shadow register and dash register are kept.
- Handshake:
  - value_ready = 1 exactly when the shadow register is empty. It is 0 during the reset cycle and 1 from the first cycle after reset release.
  - A transfer occurs when value_valid and value_ready are both 1 at a clock edge. value_in is captured into the shadow register and value_ready drops on the next cycle.
  - At every frame boundary, in either state, a full shadow register is copied to the display register and emptied; value_ready returns to 1 on the cycle frame_tick is high.
  - dash_mode is sampled into the dash register only at frame boundaries.
- Simultaneous events:
  - A transfer on the same edge as a frame boundary is captured into the shadow register and applied at the following boundary.
  - lamp_test has priority over the LAMP-to-RUN transition.
  - Nibble codes 10..15 pass through unchanged; the decoder blanks them.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined: in RUN with pattern=0, any digit above the most significant non-zero nibble outputs digit=4'hF (blank). Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Evaluated from the display register, so it is stable for the whole frame.
  - No effect in LAMP or dash mode.
- When undefined: all nibbles are output as stored.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=10, BLANK_CYC=2, LAMP_FRAMES=2.
1. Release reset → first 80 cycles: pattern=1; digit_en sequence 0000×2, 0001×8, 0000×2, 0010×8, … 1000×8; frame_tick at cycles 0 and 40. From cycle 80: pattern=0, all digits 0, value_ready=1 from cycle 1.
2. In RUN, drive 16'h1234 with valid at cycle 95 → value_ready=0 at 96; digits stay 0 until the frame_tick at 120. Then slots 0..3 show 4,3,2,1, and value_ready=1 at 120.
3. Second value 16'h5678 held valid from cycle 96 → no transfer until value_ready=1 at 120; 5678 is displayed from frame 160. 1234 is shown for exactly one frame.
4. dash_mode=1 at cycle 130 → pattern=3 from frame_tick 160. dash_mode=0 at 170 → pattern=0 from 200.
5. lamp_test pulse at cycle 213 → at 214 digit_en=0, pattern=1, frame_tick=1. Lamp lasts 80 cycles, then the previous value resumes. rst_n low for one cycle mid-slot → all outputs at reset values on the next cycle.
6. With LEADING_ZERO_BLANK_EN, load 16'h0040 → slots show 0,4,F,F. Load 16'h0000 → slots show 0,F,F,F.
